// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential instruction-memory reads from a
// fetch PC, buffers returned words with their addresses in a small circular
// queue, and flushes everything on a redirect.
module fetch_queue #(
    parameter int unsigned          ADDR_W   = 64,
    parameter int unsigned          INSTR_W  = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = 64'h0000_0000_0040_0000
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       iRedirect,
    input  logic [ADDR_W-1:0]          iRedirectPC,
    output logic                       IwReadEnable,
    output logic [ADDR_W-1:0]          IwAddress,
    input  logic [INSTR_W-1:0]         IwReadData,
    input  logic                       iIwReady,
    output logic                       oInstrValid,
    output logic [INSTR_W-1:0]         oInstr,
    output logic [ADDR_W-1:0]          oInstrPC,
    input  logic                       iInstrReady,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic [ADDR_W-1:0]          mPC
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {
        StFetch,
        StFull
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]           count_q, count_d;
    logic [ADDR_W+INSTR_W-1:0] mem_q [DEPTH];

    logic push;
    logic pop;

    // Redirect targets are word aligned; the low bits are intentionally dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^iRedirectPC[1:0];

    // Handshakes; a redirect cancels both the returning data and any pop.
    always_comb begin
        push = (state_q == StFetch) && iIwReady && !iRedirect;
        pop  = (count_q != '0) && iInstrReady && !iRedirect;
    end

    // Next-state logic for FSM, fetch PC, pointers and occupancy.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (iRedirect) begin
            state_d  = StFetch;
            pc_d     = {iRedirectPC[ADDR_W-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                pc_d     = pc_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            unique case (state_q)
                StFetch: if (push && (count_d == CntW'(DEPTH))) state_d = StFull;
                StFull:  if (pop) state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pc_q, IwReadData};
        end
    end

    // Outputs; the read request is gated by reset so it drops immediately.
    always_comb begin
        IwReadEnable       = iRST_N && (state_q == StFetch);
        IwAddress          = pc_q;
        mPC                = pc_q;
        oCount             = count_q;
        oInstrValid        = (count_q != '0);
        {oInstrPC, oInstr} = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a scoreboard records each expected
// {PC, instruction} when a fetch is accepted and checks it when consumed.
module tb_fetch_queue;

    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0040_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic               iCLK = 1'b0;
    logic               iRST_N = 1'b1;
    logic               iRedirect = 1'b0;
    logic [ADDR_W-1:0]  iRedirectPC = '0;
    logic               IwReadEnable;
    logic [ADDR_W-1:0]  IwAddress;
    logic [INSTR_W-1:0] IwReadData;
    logic               iIwReady = 1'b0;
    logic               oInstrValid;
    logic [INSTR_W-1:0] oInstr;
    logic [ADDR_W-1:0]  oInstrPC;
    logic               iInstrReady = 1'b0;
    logic [2:0]         oCount;
    logic [ADDR_W-1:0]  mPC;

    entry_t      sb[$];
    logic [63:0] exp_pc;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iRedirect   (iRedirect),
        .iRedirectPC (iRedirectPC),
        .IwReadEnable(IwReadEnable),
        .IwAddress   (IwAddress),
        .IwReadData  (IwReadData),
        .iIwReady    (iIwReady),
        .oInstrValid (oInstrValid),
        .oInstr      (oInstr),
        .oInstrPC    (oInstrPC),
        .iInstrReady (iInstrReady),
        .oCount      (oCount),
        .mPC         (mPC)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_1234;
    endfunction

    // Instruction memory model: word content derived from the address.
    assign IwReadData = mem_word(IwAddress);

    // One clock of stimulus with scoreboard bookkeeping; entered and left at posedge+1.
    task automatic step(input logic iw, input logic ir);
        entry_t e;
        iIwReady    = iw;
        iInstrReady = ir;
        total_cnt++;
        if (oCount !== 3'(sb.size())) $display("FAIL count: got %0d want %0d", oCount, sb.size());
        else pass_cnt++;
        total_cnt++;
        if (oInstrValid !== (sb.size() != 0))
            $display("FAIL valid: got %b want %b", oInstrValid, sb.size() != 0);
        else pass_cnt++;
        total_cnt++;
        if (IwReadEnable !== (sb.size() != DEPTH))
            $display("FAIL read_en: got %b want %b", IwReadEnable, sb.size() != DEPTH);
        else pass_cnt++;
        if (ir && sb.size() != 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (oInstrPC !== e.pc || oInstr !== e.instr)
                $display("FAIL head: got %h/%h want %h/%h", oInstrPC, oInstr, e.pc, e.instr);
            else pass_cnt++;
        end
        if (IwReadEnable === 1'b1) begin
            total_cnt++;
            if (IwAddress !== exp_pc) $display("FAIL address: got %h want %h", IwAddress, exp_pc);
            else pass_cnt++;
            if (iw) begin
                sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
                exp_pc = exp_pc + 64'd4;
            end
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST_N      = 1'b0;
        iIwReady    = 1'b0;
        iInstrReady = 1'b0;
        iRedirect   = 1'b0;
        #1;
        @(negedge iCLK);
        iRST_N = 1'b1;
        sb.delete();
        exp_pc = RESET_PC;
        @(posedge iCLK);
        #1;
    endtask

    // Consume everything left; bounded so a stuck queue cannot hang the run.
    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && sb.size() != 0; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        total_cnt++;
        if (sb.size() != 0) $display("FAIL drain: %0d entries left, want 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #1 iRST_N = 1'b0;
        #1;
        total_cnt++;
        if (IwReadEnable !== 1'b0 || oCount !== 3'd0 || oInstrValid !== 1'b0 || mPC !== RESET_PC)
            $display("FAIL reset: got en=%b cnt=%0d v=%b pc=%h want 0/0/0/%h",
                     IwReadEnable, oCount, oInstrValid, mPC, RESET_PC);
        else pass_cnt++;
        @(negedge iCLK);
        iRST_N = 1'b1;
        sb.delete();
        exp_pc = RESET_PC;
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_stream();
        logic [63:0] want;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            want = RESET_PC + 64'(4 * i);
            total_cnt++;
            if (IwAddress !== want || oCount > 3'd1)
                $display("FAIL stream: got addr=%h cnt=%0d want %h/<=1", IwAddress, oCount, want);
            else pass_cnt++;
            step(1'b1, 1'b1);
        end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
        total_cnt++;
        if (oCount !== 3'd4 || IwReadEnable !== 1'b0)
            $display("FAIL full: got cnt=%0d en=%b want 4/0", oCount, IwReadEnable);
        else pass_cnt++;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        total_cnt++;
        if (IwReadEnable !== 1'b1 || IwAddress !== 64'h40_0010)
            $display("FAIL full_resume: got en=%b addr=%h want 1/400010", IwReadEnable, IwAddress);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (IwReadEnable !== 1'b1 || IwAddress !== RESET_PC || oCount !== 3'd0)
                $display("FAIL stall: got en=%b addr=%h cnt=%0d want 1/%h/0",
                         IwReadEnable, IwAddress, oCount, RESET_PC);
            else pass_cnt++;
            step(1'b0, 1'b1);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        iRedirect   = 1'b1;
        iRedirectPC = 64'h1003;
        iIwReady    = 1'b1;
        iInstrReady = 1'b1;
        @(posedge iCLK);
        #1;
        iRedirect = 1'b0;
        sb.delete();
        exp_pc = 64'h1000;
        total_cnt++;
        if (oCount !== 3'd0 || oInstrValid !== 1'b0 || IwAddress !== 64'h1000 || IwReadEnable !== 1'b1)
            $display("FAIL redirect: got cnt=%0d v=%b addr=%h en=%b want 0/0/1000/1",
                     oCount, oInstrValid, IwAddress, IwReadEnable);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            total_cnt++;
            if (oCount !== 3'd2) $display("FAIL b2b_count: got %0d want 2", oCount);
            else pass_cnt++;
            step(1'b1, 1'b1);
        end
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        iIwReady = 1'b1;
        #2;
        iRST_N = 1'b0;
        #1;
        total_cnt++;
        if (oCount !== 3'd0 || oInstrValid !== 1'b0 || mPC !== RESET_PC || IwReadEnable !== 1'b0)
            $display("FAIL async_reset: got cnt=%0d v=%b pc=%h en=%b want 0/0/%h/0",
                     oCount, oInstrValid, mPC, IwReadEnable, RESET_PC);
        else pass_cnt++;
        @(posedge iCLK);
        #1;
        total_cnt++;
        if (oCount !== 3'd0 || IwReadEnable !== 1'b0)
            $display("FAIL reset_hold: got cnt=%0d en=%b want 0/0", oCount, IwReadEnable);
        else pass_cnt++;
        iIwReady = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        sb.delete();
        exp_pc = RESET_PC;
        @(posedge iCLK);
        #1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        drain();
    endtask

    initial begin
        exp_pc = RESET_PC;
        test_reset();
        test_stream();
        test_full();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
